// File: rtl/emu_ff_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// emu_ff_scan_ctrl_if
// Word streams between the scan-chain controller and the host.
//
// Handshake: a beat transfers on a rising clk edge where valid=1 and ready=1.
// Once valid is raised, the source holds it and keeps data stable until that
// transfer happens. valid never depends on ready. The controller's din_ready
// depends only on its own registered state.
//
// Signals:
//   dout_valid/dout_ready/dout_data : dump stream, controller -> host
//   din_valid/din_ready/din_data    : restore stream, host -> controller
// Modports:
//   master : controller side
//   slave  : host side
// -----------------------------------------------------------------------------
interface emu_ff_scan_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  dout_valid;
   logic                  dout_ready;
   logic [DATA_WIDTH-1:0] dout_data;
   logic                  din_valid;
   logic                  din_ready;
   logic [DATA_WIDTH-1:0] din_data;

   modport master (
      output dout_valid, dout_data, din_ready,
      input  dout_ready, din_valid, din_data
   );

   modport slave (
      input  dout_valid, dout_data, din_ready,
      output dout_ready, din_valid, din_data
   );
endinterface

// File: rtl/emu_ff_scan_ctrl.sv
// -----------------------------------------------------------------------------
// emu_ff_scan_ctrl
// Host-side controller for the emulator flip-flop scan chain. It stops the
// emulated system, shifts the whole chain once and resumes. In a dump it packs
// scan-out bits LSB-first into words and loops them back into the chain. In a
// restore it unpacks stream words into scan-in bits.
//
// Optional feature: define EMU_SCAN_CRC_EN to add a 32-bit CRC port over the
// scanned bits. The CRC has polynomial 0x04C11DB7, seed 0xFFFFFFFF, MSB-first
// shift and no final XOR.
//
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   start         : command pulse, ignored while busy
//   dir           : 0 = dump, 1 = restore (sampled on start)
//   bit_count     : chain length (sampled on start)
//   busy, done    : operation in progress / one-cycle completion pulse
//   run_mode      : to EMU_RUN_MODE
//   scan_mode     : to EMU_SCAN_MODE
//   ff_se, ff_di  : to EMU_FF_SE / EMU_FF_DI
//   ff_do         : from EMU_FF_DO
//   crc           : running CRC (EMU_SCAN_CRC_EN only)
//   dbg_state     : current FSM state encoding
//   strm          : dump/restore word streams (master side)
// -----------------------------------------------------------------------------
module emu_ff_scan_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 dir,
   input  logic [CNT_WIDTH-1:0] bit_count,
   output logic                 busy,
   output logic                 done,
   output logic                 run_mode,
   output logic                 scan_mode,
   output logic                 ff_se,
   output logic                 ff_di,
   input  logic                 ff_do,
`ifdef EMU_SCAN_CRC_EN
   output logic [31:0]          crc,
`endif
   output logic [2:0]           dbg_state,
   emu_ff_scan_ctrl_if.master   strm
);

   localparam int IDXW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STOP   = 3'd1,
      S_SCAN   = 3'd2,
      S_FLUSH  = 3'd3,
      S_RESUME = 3'd4
   } state_t;

   state_t                state;
   logic                  dir_q;
   logic [CNT_WIDTH-1:0]  remaining;
   logic [CNT_WIDTH-1:0]  words_owed;
   logic [IDXW-1:0]       bit_idx;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] sbuf;
   logic [IDXW:0]         buf_cnt;

   logic                  in_scan;
   logic                  word_end;
   logic                  dump_se;
   logic                  rest_se;
   logic                  din_rdy;
   logic                  din_fire;
   logic [DATA_WIDTH-1:0] word_next;
   logic [CNT_WIDTH:0]    owed_sum;
   logic [CNT_WIDTH-1:0]  words_init;

   // One extra bit so that ceil() cannot overflow for very long chains.
   assign owed_sum   = {1'b0, bit_count} + (CNT_WIDTH+1)'(DATA_WIDTH-1);
   assign words_init = CNT_WIDTH'(owed_sum >> IDXW);

   assign in_scan  = (state == S_SCAN) && (remaining != '0);
   // The bit shifted this cycle closes a word: either the word is full or
   // this is the last bit of the chain.
   assign word_end = (bit_idx == IDXW'(DATA_WIDTH-1)) || (remaining == CNT_WIDTH'(1));

   // A dump stalls only if the finished word has nowhere to go.
   assign dump_se = in_scan && !dir_q &&
                    !(word_end && strm.dout_valid && !strm.dout_ready);
   assign rest_se = in_scan && dir_q && (buf_cnt != '0);
   assign ff_se   = dump_se | rest_se;

   assign ff_di = ((state == S_SCAN) && dir_q) ? sbuf[0] : ff_do;

   // The buffer is refilled in the same cycle its last bit is shifted out,
   // so a restore can run at one bit per cycle.
   assign din_rdy  = (state == S_SCAN) && dir_q && (words_owed != '0) &&
                     ((buf_cnt == '0) || ((buf_cnt == (IDXW+1)'(1)) && rest_se));
   assign din_fire = din_rdy && strm.din_valid;
   assign strm.din_ready = din_rdy;

   assign word_next = acc | (DATA_WIDTH'(ff_do) << bit_idx);
   assign dbg_state = state;

`ifdef EMU_SCAN_CRC_EN
   logic        scan_bit;
   logic [31:0] crc_next;
   assign scan_bit = dir_q ? sbuf[0] : ff_do;
   assign crc_next = {crc[30:0], 1'b0} ^ ((crc[31] ^ scan_bit) ? 32'h04C11DB7 : 32'h0);
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= S_IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         run_mode        <= 1'b1;
         scan_mode       <= 1'b0;
         dir_q           <= 1'b0;
         remaining       <= '0;
         words_owed      <= '0;
         bit_idx         <= '0;
         acc             <= '0;
         sbuf            <= '0;
         buf_cnt         <= '0;
         strm.dout_valid <= 1'b0;
         strm.dout_data  <= '0;
`ifdef EMU_SCAN_CRC_EN
         crc             <= 32'hFFFFFFFF;
`endif
      end else begin
         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  dir_q      <= dir;
                  remaining  <= bit_count;
                  words_owed <= words_init;
                  bit_idx    <= '0;
                  acc        <= '0;
                  sbuf       <= '0;
                  buf_cnt    <= '0;
                  busy       <= 1'b1;
                  run_mode   <= 1'b0;
                  state      <= S_STOP;
`ifdef EMU_SCAN_CRC_EN
                  crc        <= 32'hFFFFFFFF;
`endif
               end
            end
            S_STOP: begin
               scan_mode <= 1'b1;
               state     <= S_SCAN;
            end
            S_SCAN: begin
               // The last captured bit has already been moved to dout, so
               // nothing is in flight once remaining reaches zero.
               if (remaining == '0) begin
                  scan_mode <= 1'b0;
                  state     <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (dir_q || !strm.dout_valid || strm.dout_ready) begin
                  state <= S_RESUME;
               end
            end
            S_RESUME: begin
               run_mode <= 1'b1;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (ff_se) begin
            remaining <= remaining - 1'b1;
`ifdef EMU_SCAN_CRC_EN
            crc       <= crc_next;
`endif
         end

         // Dump packing; a newly completed word overrides the clear of an
         // accepted one.
         if (strm.dout_valid && strm.dout_ready) begin
            strm.dout_valid <= 1'b0;
         end
         if (dump_se) begin
            if (word_end) begin
               strm.dout_data  <= word_next;
               strm.dout_valid <= 1'b1;
               acc             <= '0;
               bit_idx         <= '0;
            end else begin
               acc     <= word_next;
               bit_idx <= bit_idx + 1'b1;
            end
         end

         // Restore unpacking; leftover bits of the final word are never
         // shifted because ff_se stops when remaining reaches zero.
         if (din_fire) begin
            sbuf       <= strm.din_data;
            buf_cnt    <= (IDXW+1)'(DATA_WIDTH);
            words_owed <= words_owed - 1'b1;
         end else if (rest_se) begin
            sbuf    <= sbuf >> 1;
            buf_cnt <= buf_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_emu_ff_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_emu_ff_scan_ctrl
// Bench for emu_ff_scan_ctrl. A behavioural scan chain sits on ff_se/ff_di/
// ff_do. Expected dump words are queued when an operation is issued and a
// stream monitor pops them as beats are accepted.
// -----------------------------------------------------------------------------
module tb_emu_ff_scan_ctrl;
   localparam int DW = 32;
   localparam int CW = 32;
   localparam logic [127:0] PATTERN = 128'h2A_DEADBEEF_CAFEF00D;
   localparam int BUDGET = 2000;

   // clock / reset
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic          dir = 1'b0;
   logic [CW-1:0] bit_count = '0;
   logic          busy, done, run_mode, scan_mode, ff_se, ff_di, ff_do;
   logic [2:0]    dbg_state;
`ifdef EMU_SCAN_CRC_EN
   logic [31:0]   crc;
`endif

   emu_ff_scan_ctrl_if #(.DATA_WIDTH(DW)) strm();

   emu_ff_scan_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .dir       (dir),
      .bit_count (bit_count),
      .busy      (busy),
      .done      (done),
      .run_mode  (run_mode),
      .scan_mode (scan_mode),
      .ff_se     (ff_se),
      .ff_di     (ff_di),
      .ff_do     (ff_do),
`ifdef EMU_SCAN_CRC_EN
      .crc       (crc),
`endif
      .dbg_state (dbg_state),
      .strm      (strm)
   );

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // behavioural scan chain: bit 0 exits on ff_do, ff_di enters at the top
   logic [127:0] chain = '0;
   logic [127:0] load_val = '0;
   logic         load_req = 1'b0;
   int           cur_len = 1;
   int           sh_total = 0;
   int           sh_base = 0;

   assign ff_do = chain[0];

   always @(posedge clk) begin
      if (load_req) begin
         chain <= load_val;
      end else if (rstn && ff_se) begin
         chain <= chain >> 1;
         chain[cur_len-1] <= ff_di;
         sh_total <= sh_total + 1;
      end
   end

   // stream monitor / scoreboard
   int beats = 0;
   always @(negedge clk) begin
      if (rstn && strm.dout_valid && strm.dout_ready) begin
         beats <= beats + 1;
         if (exp_q.size() == 0) begin
            chk("dout_unexpected", {96'h0, strm.dout_data}, 128'h0 - 1);
         end else begin
            chk("dout_word", {96'h0, strm.dout_data}, {96'h0, exp_q.pop_front()});
         end
      end
   end

   // a shift that closes a word must not happen while the output is blocked
   int viol = 0;
   always @(negedge clk) begin
      if (rstn && ff_se && strm.dout_valid && !strm.dout_ready &&
          ((((sh_total - sh_base) % DW) == DW-1) || ((sh_total - sh_base) == cur_len-1))) begin
         viol <= viol + 1;
      end
   end

   // driver tasks
   logic [DW-1:0] rwords[3] = '{32'hCAFEF00D, 32'hDEADBEEF, 32'h0000002A};
   logic          rm_hist[0:15];
   int            accepts;
   int            done_n;

   task automatic preload(input logic [127:0] val, input int len);
      load_val = val;
      cur_len  = len;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   task automatic run_op(input logic d, input int len, input int rdy_pct,
                         input logic din_rand, input logic glitch);
      int  cyc;
      int  din_idx;
      int  nw;
      bit  seen;
      nw      = (len + DW - 1) / DW;
      accepts = 0;
      done_n  = 0;
      din_idx = 0;
      seen    = 0;
      for (int i = 0; i < 16; i++) rm_hist[i] = 1'bx;
      cur_len = (len == 0) ? 1 : len;
      sh_base = sh_total;
      @(posedge clk); #1;
      start = 1'b1; dir = d; bit_count = CW'(len);
      @(negedge clk);
      rm_hist[0] = run_mode;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!seen && cyc < BUDGET) begin
         strm.dout_ready = ($urandom_range(0, 99) < rdy_pct);
         if (glitch && cyc == 10) begin
            start = 1'b1; dir = ~d; bit_count = 5;
         end else begin
            start = 1'b0; dir = d;
         end
         if (din_idx < nw) begin
            strm.din_valid = din_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            strm.din_data  = rwords[din_idx];
         end else begin
            strm.din_valid = 1'b0;
         end
         @(negedge clk);
         if (cyc == 1) chk("busy_after_start", {127'h0, busy}, 128'h1);
         if (cyc < 16) rm_hist[cyc] = run_mode;
         if (done) begin
            done_n++;
            seen = 1;
         end
         if (strm.din_valid && strm.din_ready) begin
            accepts++;
            din_idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      strm.din_valid = 1'b0;
      strm.dout_ready = 1'b1;
      if (!seen) chk("op_timeout", 128'h0, 128'h1);
      repeat (3) begin
         @(negedge clk);
         if (done) done_n++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int b0;
      int v0;
      int n;
      logic [5:0] seq;
      strm.dout_ready = 1'b1;
      strm.din_valid  = 1'b0;
      strm.din_data   = '0;

      // reset values
      #12;
      chk("rst_run_mode",   {127'h0, run_mode},        128'h1);
      chk("rst_scan_mode",  {127'h0, scan_mode},       128'h0);
      chk("rst_ff_se",      {127'h0, ff_se},           128'h0);
      chk("rst_busy",       {127'h0, busy},            128'h0);
      chk("rst_done",       {127'h0, done},            128'h0);
      chk("rst_dout_valid", {127'h0, strm.dout_valid}, 128'h0);
      chk("rst_din_ready",  {127'h0, strm.din_ready},  128'h0);
      chk("rst_dout_data",  {96'h0, strm.dout_data},   128'h0);
`ifdef EMU_SCAN_CRC_EN
      chk("rst_crc",        {96'h0, crc},              128'hFFFFFFFF);
`endif
      @(posedge clk); #1;
      rstn = 1'b1;

      // dump, full throughput
      preload(PATTERN, 70);
      exp_q.push_back(32'hCAFEF00D);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h0000002A);
      b0 = beats;
      run_op(1'b0, 70, 100, 1'b0, 1'b0);
      chk("dump_shifts",  128'(sh_total - sh_base), 128'd70);
      chk("dump_chain",   chain, PATTERN);
      chk("dump_done",    128'(done_n), 128'd1);
      chk("dump_beats",   128'(beats - b0), 128'd3);

      // restore into a zeroed chain, random din_valid
      preload(128'h0, 70);
      b0 = beats;
      run_op(1'b1, 70, 100, 1'b1, 1'b0);
      chk("rest_chain",   chain, PATTERN);
      chk("rest_accepts", 128'(accepts), 128'd3);
      chk("rest_shifts",  128'(sh_total - sh_base), 128'd70);
      chk("rest_run_mode",{127'h0, run_mode}, 128'h1);
      chk("rest_done",    128'(done_n), 128'd1);
      chk("rest_no_dout", 128'(beats - b0), 128'd0);

      // dump with 50% back-pressure and a start while busy
      preload(PATTERN, 70);
      exp_q.push_back(32'hCAFEF00D);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h0000002A);
      b0 = beats;
      v0 = viol;
      run_op(1'b0, 70, 50, 1'b0, 1'b1);
      chk("bp_stall_rule", 128'(viol - v0), 128'd0);
      chk("bp_shifts",     128'(sh_total - sh_base), 128'd70);
      chk("bp_beats",      128'(beats - b0), 128'd3);
      chk("bp_chain",      chain, PATTERN);
      chk("bp_done",       128'(done_n), 128'd1);

      // zero-length chain
      b0 = beats;
      run_op(1'b0, 0, 100, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) seq[5-i] = rm_hist[i];
      chk("zero_shifts",   128'(sh_total - sh_base), 128'd0);
      chk("zero_beats",    128'(beats - b0), 128'd0);
      chk("zero_run_seq",  {122'h0, seq}, 128'b100001);
      chk("zero_done",     128'(done_n), 128'd1);

      // reset in the middle of a dump after 40 bits
      preload(PATTERN, 70);
      exp_q.push_back(32'hCAFEF00D);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h0000002A);
      @(posedge clk); #1;
      start = 1'b1; dir = 1'b0; bit_count = 70;
      sh_base = sh_total;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while ((sh_total - sh_base) < 40 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mid_reached_40", 128'(sh_total - sh_base), 128'd40);
      @(negedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("mid_run_mode",   {127'h0, run_mode},        128'h1);
      chk("mid_scan_mode",  {127'h0, scan_mode},       128'h0);
      chk("mid_ff_se",      {127'h0, ff_se},           128'h0);
      chk("mid_dout_valid", {127'h0, strm.dout_valid}, 128'h0);
      chk("mid_busy",       {127'h0, busy},            128'h0);
      chk("mid_exp_left",   128'(exp_q.size()),        128'd2);
      exp_q.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
      chk("mid_shift_stop", 128'(sh_total - sh_base), 128'd40);

      // fresh dump after the reset
      preload(PATTERN, 70);
      exp_q.push_back(32'hCAFEF00D);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h0000002A);
      b0 = beats;
      run_op(1'b0, 70, 100, 1'b0, 1'b0);
      chk("post_shifts", 128'(sh_total - sh_base), 128'd70);
      chk("post_beats",  128'(beats - b0), 128'd3);
      chk("post_chain",  chain, PATTERN);
      chk("post_done",   128'(done_n), 128'd1);

`ifdef EMU_SCAN_CRC_EN
      preload(128'h1, 1);
      exp_q.push_back(32'h00000001);
      run_op(1'b0, 1, 100, 1'b0, 1'b0);
      chk("crc_bit1", {96'h0, crc}, 128'hFFFFFFFE);
      preload(128'h0, 1);
      exp_q.push_back(32'h00000000);
      run_op(1'b0, 1, 100, 1'b0, 1'b0);
      chk("crc_bit0", {96'h0, crc}, 128'hFB3EE249);
`endif

      chk("exp_q_drained", 128'(exp_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/emu_ff_scan_ctrl.md
Name: emu_ff_scan_ctrl

Overview:
- Host-side controller driving the EMU_SYSTEM flip-flop scan chain. It sits directly upstream of EMU_FF_SE/EMU_FF_DI and downstream of EMU_FF_DO.
- Sequences run_mode/scan_mode around a checkpoint dump or restore.
- Dump: packs serial scan-out bits into words on an output stream.
- Restore: unpacks input-stream words into serial scan-in bits.

Parameters:
- DATA_WIDTH, 32, stream word width; power of two, ≥ 8.
- CNT_WIDTH, 32, width of the scan bit counter.

Ports:
- clk  in  1  host clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- dir  in  1  sampled on start: 0 = dump, 1 = restore.
- bit_count  in  CNT_WIDTH  chain length; sampled on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the operation completes.
- run_mode  out  1  to EMU_RUN_MODE.
- scan_mode  out  1  to EMU_SCAN_MODE.
- ff_se  out  1  to EMU_FF_SE.
- ff_di  out  1  to EMU_FF_DI.
- ff_do  in  1  from EMU_FF_DO.
- dout_valid, dout_ready, dout_data  out/in/out  1/1/DATA_WIDTH  dump word stream.
- din_valid, din_ready, din_data  in/out/in  1/1/DATA_WIDTH  restore word stream.

Behaviour:
- Reset values: run_mode=1; scan_mode=0; ff_se=0; busy=0; done=0; dout_valid=0; din_ready=0; dout_data=0.
- FSM states: IDLE → STOP → SCAN → FLUSH → RESUME → IDLE.
  - IDLE: start=1 latches dir and bit_count, clears the counters, sets busy=1, and goes to STOP.
  - STOP (1 cycle): run_mode=0, scan_mode=0.
  - SCAN: run_mode=0, scan_mode=1. Exit when the remaining-bit count reaches 0 and no bit is in flight.
  - FLUSH (dump only): hold until the final dout word is accepted. A restore passes through FLUSH in one cycle.
  - RESUME (1 cycle): scan_mode=0, run_mode=0. The next cycle is IDLE with run_mode=1 and done=1.
- Chain bit j ↔ word j/DATA_WIDTH, bit j%DATA_WIDTH (LSB first). Each ff_se=1 cycle moves exactly one bit and decrements remaining.
- ff_se is asserted only in SCAN with remaining≠0, and only under these conditions:
  - Dump: ff_se is low only when the bit would complete a word while dout_valid=1 and dout_ready=0. This gives full throughput when dout_ready is held high.
  - Restore: ff_se is high only while the input buffer holds an unconsumed bit.
- Dump data path:
  - ff_di = ff_do (loopback), so the chain state survives the dump.
  - A bit is captured from ff_do on each ff_se cycle.
  - When a word completes, or the last bit is captured, the accumulator moves to the dout register and dout_valid=1 on the next cycle.
  - Unused upper bits of a partial final word are 0.
  - dout_valid holds, with dout_data stable, until dout_ready.
- Restore data path:
  - din_ready=1 in SCAN when the buffer is empty, or is consuming its last bit this cycle, and words are still owed.
  - ff_di = buffer bit 0; the buffer shifts right on each ff_se.
  - Bits of the final word beyond bit_count are discarded.
  - Outside restore SCAN, ff_di = ff_do.
- Word count per operation = ceil(bit_count / DATA_WIDTH). No extra words are produced or consumed.
- bit_count=0: STOP → SCAN (1 cycle) → FLUSH → RESUME. No ff_se, no stream beats, done still pulses.
- start while busy: ignored; latched values are unchanged.
- Reset mid-operation: all outputs return to reset values immediately. Partial words are dropped and the counters are cleared.

Optional Feature:
- Macro EMU_SCAN_CRC_EN.
- When defined, adds output port crc (32 bits), reset value 0xFFFFFFFF.
  - crc is set to 0xFFFFFFFF on an accepted start.
  - On every ff_se cycle with bit b = the scanned bit (ff_do on dump, ff_di on restore): crc = {crc[30:0],0} ^ ((crc[31]^b) ? 0x04C11DB7 : 0).
  - There is no final XOR. crc is stable from done until the next start.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Dump, DATA_WIDTH=32, bit_count=70, chain model preloaded with pattern 0x2A_DEADBEEF_CAFEF00D (bit 0 = LSB), dout_ready=1 → three words 0xCAFEF00D, 0xDEADBEEF, 0x0000002A. Exactly 70 ff_se cycles; chain contents unchanged afterward; done pulses once.
- Restore the same three words into a zeroed chain, din_valid randomised → chain equals the pattern; din_ready accepted exactly 3 times; run_mode=1 after done.
- Dump with dout_ready randomly low 50% of cycles → identical words. ff_se is never high when a word completes while dout_valid=1 and dout_ready=0.
- bit_count=0 → no ff_se and no stream beats. run_mode sequence is 1,0,0,0,0,1 from the start cycle; done pulses.
- rstn low mid-SCAN after 40 bits → run_mode=1, scan_mode=0, ff_se=0, dout_valid=0 asynchronously. A new dump then completes correctly.
- With EMU_SCAN_CRC_EN, one-bit dump of chain bit 1 → crc=0xFFFFFFFE; of chain bit 0 → crc=0xFB3EE249.
